// File: rtl/regfile_wb.sv
// Architectural register file for the writeback stage.
// Two zero-latency read ports with write-through bypass, one write port,
// and a pending-write scoreboard that lets decode stall on RAW hazards
// against multi-cycle producers. Register r0 is hardwired to zero.
module regfile_wb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic                rd_use_a,
    output logic [DATA_W-1:0]   rd_data_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    input  logic                rd_use_b,
    output logic [DATA_W-1:0]   rd_data_b,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   indata,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_addr,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              hz_a;
    logic              hz_b;
    logic              wr_live;
    logic              issue_live;

    // A write to r0 is discarded entirely; an issue is blocked while decode stalls.
    assign wr_live    = wr_en && (wr_addr != '0);
    assign issue_live = issue_en && !stall && (issue_addr != '0);

    // Read with r0 forced to zero and same-cycle writeback forwarded.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (addr == '0)
            return '0;
        else if (wr_en && (wr_addr == addr))
            return indata;
        else
            return regs[addr];
    endfunction

    // A consumed operand is hazardous if pending and not resolved by this cycle's writeback.
    function automatic logic hazard(input logic use_x, input logic [ADDR_W-1:0] addr);
        return use_x && (addr != '0) && pending[addr] &&
               !(wr_en && (wr_addr == addr));
    endfunction

    // Combinational read ports and stall generation.
    always_comb begin
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
        hz_a      = hazard(rd_use_a, rd_addr_a);
        hz_b      = hazard(rd_use_b, rd_addr_b);
        stall     = hz_a | hz_b;
    end

    // Register storage: cleared on reset, written by the writeback port.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (wr_live) begin
            regs[wr_addr] <= indata;
        end
    end

    // Scoreboard: writeback clears, issue sets; issue is applied last so it wins on a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (wr_live)
                pending[wr_addr] <= 1'b0;
            if (issue_live)
                pending[issue_addr] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios followed by random
// traffic, all compared against a behavioural register-file model.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_a;
    logic        rd_use_a;
    logic [31:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic        rd_use_b;
    logic [31:0] rd_data_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] indata;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        stall;
    logic [31:0] pending;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    bit          m_pend [32];

    regfile_wb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr_a  (rd_addr_a),
        .rd_use_a   (rd_use_a),
        .rd_data_a  (rd_data_a),
        .rd_addr_b  (rd_addr_b),
        .rd_use_b   (rd_use_b),
        .rd_data_b  (rd_data_b),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .indata     (indata),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .stall      (stall),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wr_en && wr_addr == a) return indata;
        return m_regs[a];
    endfunction

    function automatic logic m_stall();
        logic ha, hb;
        ha = rd_use_a && rd_addr_a != 0 && m_pend[rd_addr_a] && !(wr_en && wr_addr == rd_addr_a);
        hb = rd_use_b && rd_addr_b != 0 && m_pend[rd_addr_b] && !(wr_en && wr_addr == rd_addr_b);
        return ha || hb;
    endfunction

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic idle();
        rst = 0; rd_addr_a = 0; rd_use_a = 0; rd_addr_b = 0; rd_use_b = 0;
        wr_en = 0; wr_addr = 0; indata = 0; issue_en = 0; issue_addr = 0;
    endtask

    // Compare every output against the model; inputs were driven at the negedge.
    task automatic check_all(input string tag);
        #1;
        chk({tag, "_rd_a"}, rd_data_a, m_read(rd_addr_a));
        chk({tag, "_rd_b"}, rd_data_b, m_read(rd_addr_b));
        chk({tag, "_stall"}, {31'd0, stall}, {31'd0, m_stall()});
        chk({tag, "_pend"}, pending, m_pend_vec());
    endtask

    // Advance the model by one clock edge, then the DUT, ending at the negedge.
    task automatic tick();
        logic st;
        st = m_stall();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 0;
                m_pend[i] = 0;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = indata;
                m_pend[wr_addr] = 0;
            end
            if (issue_en && !st && issue_addr != 0) m_pend[issue_addr] = 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 0;
            m_pend[i] = 0;
        end
        idle();
        rst = 1;
        @(negedge clk);
        tick();
        rst = 0;
        check_all("post_reset");

        // Scenario 1: random writes and issues, then a single reset cycle
        for (int i = 0; i < 20; i++) begin
            idle();
            wr_en = 1; wr_addr = 5'($urandom_range(31)); indata = $urandom;
            issue_en = 1; issue_addr = 5'($urandom_range(31));
            tick();
        end
        idle();
        rst = 1;
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
            #1;
            chk("s1_rd_a_zero", rd_data_a, 32'd0);
            chk("s1_rd_b_zero", rd_data_b, 32'd0);
            tick();
        end
        chk("s1_pend_zero", pending, 32'd0);
        chk("s1_stall_zero", {31'd0, stall}, 32'd0);

        // Scenario 2: write-through bypass then stored value
        idle();
        wr_en = 1; wr_addr = 5; indata = 32'hDEADBEEF; rd_addr_a = 5;
        #1 chk("s2_bypass", rd_data_a, 32'hDEADBEEF);
        tick();
        wr_en = 0;
        #1 chk("s2_stored", rd_data_a, 32'hDEADBEEF);
        check_all("s2");

        // Scenario 3: writes to r0 are discarded
        idle();
        wr_en = 1; wr_addr = 0; indata = 32'hFFFFFFFF;
        #1;
        chk("s3_a_same", rd_data_a, 32'd0);
        chk("s3_b_same", rd_data_b, 32'd0);
        tick();
        wr_en = 0;
        #1;
        chk("s3_a_after", rd_data_a, 32'd0);
        chk("s3_b_after", rd_data_b, 32'd0);

        // Scenario 4: pending register stalls until writeback resolves it
        idle();
        issue_en = 1; issue_addr = 7;
        tick();
        idle();
        rd_addr_b = 7; rd_use_b = 1;
        #1 chk("s4_stall_use", {31'd0, stall}, 32'd1);
        rd_use_b = 0;
        #1 chk("s4_stall_nouse", {31'd0, stall}, 32'd0);
        rd_use_b = 1; wr_en = 1; wr_addr = 7; indata = 12;
        #1;
        chk("s4_stall_wb", {31'd0, stall}, 32'd0);
        chk("s4_rd_b_wb", rd_data_b, 32'd12);
        tick();
        idle();
        #1 chk("s4_pend7_clr", {31'd0, pending[7]}, 32'd0);

        // Scenario 5: issue and write to the same register, set wins
        idle();
        issue_en = 1; issue_addr = 3; wr_en = 1; wr_addr = 3; indata = 9;
        tick();
        idle();
        rd_addr_a = 3; rd_use_a = 1;
        #1;
        chk("s5_reg3", rd_data_a, 32'd9);
        chk("s5_pend3", {31'd0, pending[3]}, 32'd1);
        chk("s5_stall", {31'd0, stall}, 32'd1);

        // Scenario 6: issue ignored under stall; reset clears scoreboard
        issue_en = 1; issue_addr = 4;
        tick();
        #1 chk("s6_pend4", {31'd0, pending[4]}, 32'd0);
        idle();
        issue_en = 1; issue_addr = 7;
        tick();
        idle();
        rd_addr_a = 7; rd_use_a = 1;
        #1 chk("s6_stall_pre", {31'd0, stall}, 32'd1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("s6_pend_rst", pending, 32'd0);
        chk("s6_stall_rst", {31'd0, stall}, 32'd0);
        check_all("s6");

        // Random traffic; narrow address range half the time to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [4:0] mask;
            mask = ($urandom_range(1) == 1) ? 5'd7 : 5'd31;
            idle();
            rst        = ($urandom_range(59) == 0);
            rd_addr_a  = 5'($urandom) & mask;
            rd_use_a   = 1'($urandom);
            rd_addr_b  = 5'($urandom) & mask;
            rd_use_b   = 1'($urandom);
            wr_en      = 1'($urandom);
            wr_addr    = 5'($urandom) & mask;
            indata     = $urandom;
            issue_en   = 1'($urandom);
            issue_addr = 5'($urandom) & mask;
            check_all("rnd");
            tick();
        end
        idle();
        check_all("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
